// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the SRAM request controller.
//   state_t : controller FSM state encoding
//   RD_LAT  : cycles from read accept edge to the rsp_valid cycle (inclusive)
//   WR_LAT  : cycles from write accept edge to the rsp_valid cycle (inclusive)
package sram_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_WAIT = 3'd2,
    RD_CAP  = 3'd3,
    WR_ADDR = 3'd4,
    WR_LOAD = 3'd5,
    WR_HOLD = 3'd6
  } state_t;

  localparam int unsigned RD_LAT = 4;
  localparam int unsigned WR_LAT = 4;

  // States during which the SRAM pin stage must see write mode.
  function automatic logic is_write_drive(input state_t s);
    return (s == WR_LOAD) || (s == WR_HOLD);
  endfunction

endpackage

// File: rtl/sram_req_ctrl.sv
// SRAM request controller: accepts one read or write request at a time from a
// valid/ready interface and sequences it to a registered SRAM pin stage.
// Ports:
//   CLK, RST              : clock (rising edge), asynchronous active-high reset
//   req_valid/req_ready   : request handshake; ready only in IDLE
//   req_write             : 1 = write, 0 = read
//   req_addr, req_wdata   : request address / write data (sampled on accept)
//   rsp_valid             : one-cycle completion pulse, no backpressure
//   rsp_rdata             : read data, valid while rsp_valid follows a read
//   mode_R1_W0            : to pin stage, 1 = read/idle, 0 = write
//   SRAM_ADDR_Stream      : address to pin stage
//   SRAM_DATA_IN_Stream   : write data to pin stage
//   SRAM_DATA_OUT_Stream  : registered read data from pin stage
module sram_req_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDRW = 20,
  parameter int DATAW = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [ADDRW-1:0] req_addr,
  input  logic [DATAW-1:0] req_wdata,
  output logic             rsp_valid,
  output logic [DATAW-1:0] rsp_rdata,
  output logic             mode_R1_W0,
  output logic [ADDRW-1:0] SRAM_ADDR_Stream,
  output logic [DATAW-1:0] SRAM_DATA_IN_Stream,
  input  logic [DATAW-1:0] SRAM_DATA_OUT_Stream
);

  state_t           r_state;
  state_t           w_next;
  logic             w_accept;
  logic             w_mode_next;
  logic             r_mode;
  logic             r_rsp_valid;
  logic [DATAW-1:0] r_rdata;
  logic [ADDRW-1:0] r_addr;
  logic [DATAW-1:0] r_wdata;

  // Gated by RST so nothing can be accepted while reset is held.
  assign req_ready = (r_state == IDLE) && !RST;
  assign w_accept  = req_valid && req_ready;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_next = req_write ? WR_ADDR : RD_ADDR;
      RD_ADDR: w_next = RD_WAIT;
      RD_WAIT: w_next = RD_CAP;
      RD_CAP:  w_next = IDLE;
      WR_ADDR: w_next = WR_LOAD;
      WR_LOAD: w_next = WR_HOLD;
      WR_HOLD: w_next = IDLE;
      default: w_next = IDLE;
    endcase
    // Mode is registered from the next state so it is glitch-free at the pins
    // and low exactly while the FSM sits in WR_LOAD/WR_HOLD.
    w_mode_next = !is_write_drive(w_next);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= IDLE;
      r_mode      <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rdata     <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
    end else begin
      r_state     <= w_next;
      r_mode      <= w_mode_next;
      // Completion pulse lands in the IDLE cycle after the last busy state.
      r_rsp_valid <= (r_state == RD_CAP) || (r_state == WR_HOLD);
      if (r_state == RD_CAP) r_rdata <= SRAM_DATA_OUT_Stream;
      if (w_accept) begin
        r_addr <= req_addr;
        if (req_write) r_wdata <= req_wdata;
      end
    end
  end

  assign rsp_valid           = r_rsp_valid;
  assign rsp_rdata           = r_rdata;
  assign mode_R1_W0          = r_mode;
  assign SRAM_ADDR_Stream    = r_addr;
  assign SRAM_DATA_IN_Stream = r_wdata;

endmodule

// File: tb/tb_sram_req_ctrl.sv
// Directed bench for sram_req_ctrl with a registered SRAM pin-stage model.
module tb_sram_req_ctrl;

  localparam int ADDRW = 20;
  localparam int DATAW = 16;

  logic             CLK;
  logic             RST;
  logic             req_valid;
  logic             req_ready;
  logic             req_write;
  logic [ADDRW-1:0] req_addr;
  logic [DATAW-1:0] req_wdata;
  logic             rsp_valid;
  logic [DATAW-1:0] rsp_rdata;
  logic             mode_R1_W0;
  logic [ADDRW-1:0] SRAM_ADDR_Stream;
  logic [DATAW-1:0] SRAM_DATA_IN_Stream;
  logic [DATAW-1:0] SRAM_DATA_OUT_Stream;

  int checks = 0;
  int errors = 0;

  sram_req_ctrl #(.ADDRW(ADDRW), .DATAW(DATAW)) dut (
    .CLK                 (CLK),
    .RST                 (RST),
    .req_valid           (req_valid),
    .req_ready           (req_ready),
    .req_write           (req_write),
    .req_addr            (req_addr),
    .req_wdata           (req_wdata),
    .rsp_valid           (rsp_valid),
    .rsp_rdata           (rsp_rdata),
    .mode_R1_W0          (mode_R1_W0),
    .SRAM_ADDR_Stream    (SRAM_ADDR_Stream),
    .SRAM_DATA_IN_Stream (SRAM_DATA_IN_Stream),
    .SRAM_DATA_OUT_Stream(SRAM_DATA_OUT_Stream)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Pin-stage model: registered read of the current address, write when mode is 0.
  logic [DATAW-1:0] mem [logic [ADDRW-1:0]];
  always @(posedge CLK) begin
    SRAM_DATA_OUT_Stream <= mem.exists(SRAM_ADDR_Stream) ? mem[SRAM_ADDR_Stream] : '0;
    if (mode_R1_W0 == 1'b0) mem[SRAM_ADDR_Stream] = SRAM_DATA_IN_Stream;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST       = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    SRAM_DATA_OUT_Stream = '0;
    mem[20'h01234] = 16'hBEEF;

    #2 RST = 1'b1;
    tick();
    tick();
    chk("rst_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_mode",  {31'd0, mode_R1_W0}, 32'd1);
    chk("rst_rspv",  {31'd0, rsp_valid}, 32'd0);
    chk("rst_rdata", {16'd0, rsp_rdata}, 32'd0);
    chk("rst_addr",  {12'd0, SRAM_ADDR_Stream}, 32'd0);
    chk("rst_din",   {16'd0, SRAM_DATA_IN_Stream}, 32'd0);
    RST = 1'b0;
    #1;
    chk("idle_ready", {31'd0, req_ready}, 32'd1);

    // ---- Read 0x01234 -> 0xBEEF, with busy probe during RD_WAIT ----
    req_valid = 1'b1; req_write = 1'b0; req_addr = 20'h01234; req_wdata = 16'h7777;
    tick();                                   // cycle 1: RD_ADDR
    req_valid = 1'b0;
    chk("rd_c1_ready", {31'd0, req_ready}, 32'd0);
    chk("rd_c1_addr",  {12'd0, SRAM_ADDR_Stream}, 32'h01234);
    chk("rd_c1_din",   {16'd0, SRAM_DATA_IN_Stream}, 32'd0);
    chk("rd_c1_mode",  {31'd0, mode_R1_W0}, 32'd1);
    tick();                                   // cycle 2: RD_WAIT
    req_valid = 1'b1; req_write = 1'b1; req_addr = 20'h0ABCD;
    chk("rd_c2_ready", {31'd0, req_ready}, 32'd0);
    chk("rd_c2_rspv",  {31'd0, rsp_valid}, 32'd0);
    chk("rd_c2_mode",  {31'd0, mode_R1_W0}, 32'd1);
    tick();                                   // cycle 3: RD_CAP
    req_addr = 20'h05555;
    chk("busy_ready", {31'd0, req_ready}, 32'd0);
    chk("busy_addr",  {12'd0, SRAM_ADDR_Stream}, 32'h01234);
    chk("rd_c3_rspv", {31'd0, rsp_valid}, 32'd0);
    chk("rd_c3_mode", {31'd0, mode_R1_W0}, 32'd1);
    req_valid = 1'b0;
    tick();                                   // cycle 4: IDLE + rsp
    chk("rd_c4_rspv",  {31'd0, rsp_valid}, 32'd1);
    chk("rd_c4_rdata", {16'd0, rsp_rdata}, 32'hBEEF);
    chk("rd_c4_ready", {31'd0, req_ready}, 32'd1);
    chk("rd_c4_mode",  {31'd0, mode_R1_W0}, 32'd1);
    tick();
    chk("rd_c5_rspv",  {31'd0, rsp_valid}, 32'd0);
    chk("rd_c5_addr",  {12'd0, SRAM_ADDR_Stream}, 32'h01234);

    // ---- Write 0xFFFFF <- 0xA5A5 ----
    req_valid = 1'b1; req_write = 1'b1; req_addr = 20'hFFFFF; req_wdata = 16'hA5A5;
    tick();                                   // cycle 1: WR_ADDR
    req_valid = 1'b0; req_wdata = 16'h1111; req_addr = 20'h00001;
    chk("wr_c1_mode", {31'd0, mode_R1_W0}, 32'd1);
    chk("wr_c1_addr", {12'd0, SRAM_ADDR_Stream}, 32'hFFFFF);
    chk("wr_c1_din",  {16'd0, SRAM_DATA_IN_Stream}, 32'hA5A5);
    tick();                                   // cycle 2: WR_LOAD
    chk("wr_c2_mode", {31'd0, mode_R1_W0}, 32'd0);
    chk("wr_c2_din",  {16'd0, SRAM_DATA_IN_Stream}, 32'hA5A5);
    tick();                                   // cycle 3: WR_HOLD
    chk("wr_c3_mode", {31'd0, mode_R1_W0}, 32'd0);
    chk("wr_c3_rspv", {31'd0, rsp_valid}, 32'd0);
    tick();                                   // cycle 4: IDLE + rsp
    chk("wr_c4_mode",  {31'd0, mode_R1_W0}, 32'd1);
    chk("wr_c4_rspv",  {31'd0, rsp_valid}, 32'd1);
    chk("wr_c4_rdata", {16'd0, rsp_rdata}, 32'hBEEF);
    chk("wr_c4_addr",  {12'd0, SRAM_ADDR_Stream}, 32'hFFFFF);
    chk("wr_mem", {16'd0, (mem.exists(20'hFFFFF) ? mem[20'hFFFFF] : 16'h0000)}, 32'hA5A5);
    tick();
    chk("wr_c5_rspv", {31'd0, rsp_valid}, 32'd0);

    // ---- Back-to-back: write 0x00010 <- 0x5555, then read 0x00010 ----
    req_valid = 1'b1; req_write = 1'b1; req_addr = 20'h00010; req_wdata = 16'h5555;
    tick();                                   // cycle 1
    req_write = 1'b0; req_wdata = 16'h0F0F;   // valid held; read queued
    tick();                                   // cycle 2
    tick();                                   // cycle 3
    tick();                                   // cycle 4: rsp + second accept
    chk("b2b_c4_rspv",  {31'd0, rsp_valid}, 32'd1);
    chk("b2b_c4_ready", {31'd0, req_ready}, 32'd1);
    tick();                                   // cycle 5: RD_ADDR
    req_valid = 1'b0;
    chk("b2b_c5_ready", {31'd0, req_ready}, 32'd0);
    chk("b2b_c5_rspv",  {31'd0, rsp_valid}, 32'd0);
    chk("b2b_c5_din",   {16'd0, SRAM_DATA_IN_Stream}, 32'h5555);
    tick();                                   // cycle 6
    tick();                                   // cycle 7
    chk("b2b_c7_rspv",  {31'd0, rsp_valid}, 32'd0);
    tick();                                   // cycle 8
    chk("b2b_c8_rspv",  {31'd0, rsp_valid}, 32'd1);
    chk("b2b_c8_rdata", {16'd0, rsp_rdata}, 32'h5555);
    tick();

    // ---- Reset during WR_LOAD ----
    req_valid = 1'b1; req_write = 1'b1; req_addr = 20'h00ABC; req_wdata = 16'h1234;
    tick();                                   // cycle 1: WR_ADDR
    req_valid = 1'b0;
    tick();                                   // cycle 2: WR_LOAD
    chk("mid_mode_pre", {31'd0, mode_R1_W0}, 32'd0);
    RST = 1'b1;
    #1;
    chk("mid_mode",  {31'd0, mode_R1_W0}, 32'd1);
    chk("mid_ready", {31'd0, req_ready}, 32'd0);
    chk("mid_addr",  {12'd0, SRAM_ADDR_Stream}, 32'd0);
    chk("mid_din",   {16'd0, SRAM_DATA_IN_Stream}, 32'd0);
    chk("mid_rdata", {16'd0, rsp_rdata}, 32'd0);
    chk("mid_rspv",  {31'd0, rsp_valid}, 32'd0);
    tick();
    tick();
    chk("mid_rspv_hold", {31'd0, rsp_valid}, 32'd0);
    RST = 1'b0;
    #1;
    chk("post_ready", {31'd0, req_ready}, 32'd1);
    tick();
    chk("post_rspv", {31'd0, rsp_valid}, 32'd0);
    chk("post_mode", {31'd0, mode_R1_W0}, 32'd1);
    chk("post_mem",  {31'd0, mem.exists(20'h00ABC)}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
